// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Command sequencer in front of a shared DATA_W-bit combinational ALU.
// Single-op commands are passed to the ALU for one cycle. Unsigned multiply
// commands run as a DATA_W-iteration shift-add loop that reuses the ALU adder.
// Results and flags are returned through a registered output handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its payload steady until that edge.
// in_ready depends only on state, never on in_valid. out_valid and out_*
// are registered, and they do not change while out_valid is waiting for out_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid/in_ready           command handshake
//   in_cmd[3:0]                 [3]=1 unsigned multiply, else ALUctr=[2:0]
//   in_a, in_b                  operands (multiplicand / multiplier)
//   alu_a, alu_b, alu_ctr       drive to the ALU
//   alu_f, alu_cf, alu_zero,
//   alu_of                      ALU result and flags
//   out_valid/out_ready         result handshake
//   out_result[2*DATA_W-1:0]    result (single ops are zero-extended)
//   out_cf, out_zero, out_of    flags
//   busy                        high whenever the sequencer is not IDLE
//   dbg_state[1:0]              FSM state: 0 IDLE, 1 EXEC, 2 MUL, 3 DONE
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_cmd,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_ctr,
  input  logic [DATA_W-1:0]     alu_f,
  input  logic                  alu_cf,
  input  logic                  alu_zero,
  input  logic                  alu_of,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_result,
  output logic                  out_cf,
  output logic                  out_zero,
  output logic                  out_of,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   a_q;     // operand A, multiplicand M during multiply
  logic [DATA_W-1:0]   b_q;     // operand B, doubles as P_lo during multiply
  logic [DATA_W-1:0]   p_hi_q;  // high half of the partial product
  logic [2:0]          ctr_q;
  logic [CNT_W-1:0]    cnt_q;

  // One shift-add step: {carry, sum, P_lo} shifted right by one, keeping
  // the low 2*DATA_W bits. The bit shifted out of P_lo has already been used.
  logic [2*DATA_W:0]   step_wide;
  logic [2*DATA_W-1:0] step_prod;
  logic                last_iter;

  always_comb begin
    step_wide = {alu_cf, alu_f, b_q} >> 1;
    step_prod = step_wide[2*DATA_W-1:0];
    last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      p_hi_q     <= '0;
      ctr_q      <= 3'b000;
      cnt_q      <= '0;
      out_result <= '0;
      out_cf     <= 1'b0;
      out_zero   <= 1'b0;
      out_of     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            ctr_q  <= in_cmd[2:0];
            p_hi_q <= '0;
            cnt_q  <= '0;
            state  <= in_cmd[3] ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          out_result <= {{DATA_W{1'b0}}, alu_f};
          out_cf     <= alu_cf;
          out_zero   <= alu_zero;
          out_of     <= alu_of;
          state      <= S_DONE;
        end
        S_MUL: begin
          p_hi_q <= step_prod[2*DATA_W-1:DATA_W];
          b_q    <= step_prod[DATA_W-1:0];
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            out_result <= step_prod;
            out_cf     <= 1'b0;
            out_zero   <= (step_prod == '0);
            out_of     <= (step_prod[2*DATA_W-1:DATA_W] != '0);
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU drive: idle value is add of zeros so the shared ALU sees a quiet bus.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 3'b000;
    case (state)
      S_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_ctr = ctr_q;
      end
      S_MUL: begin
        alu_a   = p_hi_q;
        alu_b   = b_q[0] ? a_q : '0;
        alu_ctr = 3'b000;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Command sequencer sitting in front of the shared 4-bit combinational ALU (ALUctr encoding: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed gt, 111 eq).
- Accepts commands over a valid/ready handshake and drives the ALU's A/B/ALUctr inputs.
- Single-op commands pass through in one ALU cycle.
- Multiply commands are executed as a multi-cycle unsigned shift-add sequence that reuses the ALU adder.
- Results and flags are returned over a second valid/ready handshake.

Parameters:
- DATA_W, 4, operand width; must equal ALU width. Multiply iteration count = DATA_W; product width = 2*DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready at a rising edge
- in_cmd  in  4  [3]=1: unsigned multiply; [3]=0: single op with ALUctr=in_cmd[2:0]
- in_a  in  DATA_W  operand A (multiplicand for multiply)
- in_b  in  DATA_W  operand B (multiplier for multiply)
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_ctr  out  3  to ALU ALUctr
- alu_f  in  DATA_W  from ALU F
- alu_cf  in  1  from ALU carry
- alu_zero  in  1  from ALU zero
- alu_of  in  1  from ALU overflow
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at a rising edge
- out_result  out  2*DATA_W  result
- out_cf  out  1  carry flag
- out_zero  out  1  zero flag
- out_of  out  1  overflow flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - State = IDLE, counter = 0, operand and product registers = 0.
  - out_valid=0, out_result=0, out_cf=0, out_zero=0, out_of=0, busy=0.
  - The in-flight command is discarded.
- States:
  - IDLE: in_ready=1. On accept, latch in_a/in_b/in_cmd. Go to EXEC if in_cmd[3]=0; go to MUL if in_cmd[3]=1 (P_hi=0, P_lo=in_b, M=in_a, cnt=0).
  - EXEC: one cycle. alu_a=latched A, alu_b=latched B, alu_ctr=latched cmd[2:0]. At the next edge capture out_result={0,alu_f}, out_cf=alu_cf, out_zero=alu_zero, out_of=alu_of, then go to DONE.
  - MUL: one cycle per iteration, DATA_W iterations.
    - Each iteration: alu_ctr=000, alu_a=P_hi, alu_b = P_lo[0] ? M : 0.
    - At the edge: {P_hi,P_lo} <= {alu_cf, alu_f, P_lo} >> 1, taken over 2*DATA_W+1 bits with the low bits discarded; cnt++.
    - After the iteration with cnt=DATA_W-1, capture out_result={P_hi,P_lo} (post-shift value), out_cf=0, out_zero=(product==0), out_of=(product[2*DATA_W-1:DATA_W]!=0). Go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE with out_valid=0 at that edge.
- in_ready is low in EXEC, MUL and DONE. There is no command queuing; a new command is accepted only one cycle after result handoff.
- ALU drive in IDLE and DONE: alu_a=0, alu_b=0, alu_ctr=000.
- Latency from the accepting edge to out_valid rising:
  - Single op: 1 cycle.
  - Multiply: DATA_W cycles (4 by default).
- out_* registers change only on capture or reset. Their values persist after handoff until the next capture.
- in_a/in_b/in_cmd are ignored outside the accepting edge; input changes mid-operation have no effect.
- The sequencer never interprets alu_ctr=110/111 results; it passes them through as F, zero-extended.

Test Plan:
- Single op: cmd=0000, A=3, B=4 -> one cycle after accept: out_valid=1, out_result=0x07, cf=0, zero=0, of=0.
- Overflow pass-through: cmd=0000, A=7, B=1 -> out_result=0x08, of=1, cf=0. Also cmd=0001, A=0, B=1 -> out_result=0x0F, cf=1.
- Multiply max: cmd=1000, A=15, B=15 -> busy for 4 cycles, then out_valid=1, out_result=0xE1, of=1, zero=0, cf=0. Check alu_ctr=000 in every MUL cycle.
- Multiply zero and small:
  - A=9, B=0 -> out_result=0x00, zero=1, of=0.
  - A=3, B=5 -> out_result=0x0F, of=0.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid and outputs stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> out_valid drops and in_ready rises at the same edge.
- Reset mid-multiply: assert rst_n=0 asynchronously in the 2nd MUL cycle -> immediately out_valid=0, busy=0, outputs 0. After release, A=2, B=6 -> out_result=0x0C.
